// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_NUM_SETS       = 64;
  localparam int DEF_WORDS_PER_LINE = 4;

  // Byte-offset width inside one bus word.
  function automatic int byte_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Field width for a power-of-two count, never narrower than one bit.
  function automatic int field_bits(input int count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Per-set tag store plus valid bits; valid clears asynchronously, tags are plain storage.
module dcache_tag_array #(
  parameter int NUM_SETS = 64,
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] i_idx,
  input  logic [TAG_BITS-1:0] i_tag,
  input  logic                i_inv,
  input  logic                i_we,
  output logic                o_hit
);

  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_BITS-1:0] r_tag [NUM_SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_valid        <= '0;
    else if (i_we)  r_valid[i_idx] <= 1'b1;
    else if (i_inv) r_valid[i_idx] <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (i_we) r_tag[i_idx] <= i_tag;
  end

  assign o_hit = r_valid[i_idx] && (r_tag[i_idx] == i_tag);

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a stalling CPU side.
module dcache
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NUM_SETS       = DEF_NUM_SETS,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_rd,
  input  logic                    cpu_wr,
  input  logic [DATA_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_byte_en,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_byte_en,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack
);

  localparam int NBYTES    = DATA_WIDTH / 8;
  localparam int BYTE_BITS = byte_bits(DATA_WIDTH);
  localparam int WORD_BITS = field_bits(WORDS_PER_LINE);
  localparam int IDX_BITS  = field_bits(NUM_SETS);
  localparam int TAG_BITS  = DATA_WIDTH - IDX_BITS - WORD_BITS - BYTE_BITS;
  localparam int NWORDS    = NUM_SETS * WORDS_PER_LINE;
  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(WORDS_PER_LINE - 1);

  state_t                         r_state;
  logic [WORD_BITS-1:0]           r_cnt;
  logic [DATA_WIDTH-1:0]          r_data [NWORDS];

  logic [TAG_BITS-1:0]            w_tag;
  logic [IDX_BITS-1:0]            w_idx;
  logic [WORD_BITS-1:0]           w_word;
  logic [IDX_BITS+WORD_BITS-1:0]  w_cpu_ptr;
  logic [IDX_BITS+WORD_BITS-1:0]  w_fill_ptr;
  logic                           w_hit;
  logic                           w_miss_start;
  logic                           w_fill_we;
  logic                           w_line_done;
  logic                           w_store_we;
  logic                           w_stall;
  logic                           w_unused_lo;

  assign w_tag      = cpu_addr[DATA_WIDTH-1 -: TAG_BITS];
  assign w_idx      = cpu_addr[BYTE_BITS+WORD_BITS +: IDX_BITS];
  assign w_word     = cpu_addr[BYTE_BITS +: WORD_BITS];
  assign w_cpu_ptr  = {w_idx, w_word};
  assign w_fill_ptr = {w_idx, r_cnt};
  assign w_unused_lo = &{1'b0, cpu_addr[BYTE_BITS-1:0]};

  // A store wins over a simultaneous load, so a miss only starts on a pure read.
  assign w_miss_start = (r_state == S_IDLE) && cpu_rd && !cpu_wr && !w_hit;
  assign w_fill_we    = (r_state == S_REFILL) && mem_ack;
  assign w_line_done  = w_fill_we && (r_cnt == LAST_WORD);
  assign w_store_we   = (r_state == S_WRITE) && mem_ack && w_hit;

  dcache_tag_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_tags (
    .clk   (clk),
    .rst   (rst),
    .i_idx (w_idx),
    .i_tag (w_tag),
    .i_inv (w_miss_start),
    .i_we  (w_line_done),
    .o_hit (w_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cpu_wr) begin
            r_state <= S_WRITE;
          end else if (w_miss_start) begin
            r_state <= S_REFILL;
            r_cnt   <= '0;
          end
        end
        S_REFILL: begin
          if (mem_ack) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_WORD) r_state <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (mem_ack) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Refill and store-merge never coincide: they belong to different states.
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_data[w_fill_ptr] <= mem_rdata;
    end else if (w_store_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (cpu_byte_en[b]) r_data[w_cpu_ptr][8*b +: 8] <= cpu_wdata[8*b +: 8];
      end
    end
  end

  assign cpu_rdata = r_data[w_cpu_ptr];

  always_comb begin
    w_stall = 1'b0;
    unique case (r_state)
      S_IDLE:   w_stall = cpu_wr || (cpu_rd && !w_hit);
      S_REFILL: w_stall = 1'b1;
      S_WRITE:  w_stall = !mem_ack;
      default:  w_stall = 1'b0;
    endcase
  end

  assign stall       = rst && w_stall;
  assign mem_req     = rst && (r_state != S_IDLE);
  assign mem_we      = rst && (r_state == S_WRITE);
  assign mem_addr    = (r_state == S_REFILL)
                     ? {w_tag, w_idx, r_cnt, {BYTE_BITS{1'b0}}}
                     : {cpu_addr[DATA_WIDTH-1:BYTE_BITS], {BYTE_BITS{1'b0}}};
  assign mem_wdata   = cpu_wdata;
  assign mem_byte_en = cpu_byte_en;

endmodule
